aes_core_sched: RTL and testbench

Two-port request scheduler in front of the single `aes_cipher_top` instance. Accepts independent key/plaintext jobs from two requesters (port 0: EIM host register file, port 1: on-chip self-test/spare), grants the core round-robin, sequences the `ld` pulse, waits for `done`, and returns the 128-bit ciphertext on the granting port's response channel. Sits between the bus-side logic and the cipher core. The top level drives the core's `clk`/`rst` from the same nets.

---
 rtl/aes_core_sched.sv | 194 +++++++++++++++++++
 tb/tb_aes_core_sched.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_core_sched.sv
// rtl/aes_core_sched.sv - two-port round-robin job scheduler for aes_cipher_top; WAIT watchdog built when AES_SCHED_TIMEOUT_EN is defined
module aes_core_sched #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    // requester ports: key/plaintext jobs
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_key,
    input  logic [127:0] req0_text,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_key,
    input  logic [127:0] req1_text,
    // response ports: ciphertext or watchdog error
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [127:0] rsp0_data,
    output logic         rsp0_err,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [127:0] rsp1_data,
    output logic         rsp1_err,
    // cipher core side
    output logic         core_ld,
    output logic [127:0] core_key,
    output logic [127:0] core_text_in,
    input  logic         core_done,
    input  logic [127:0] core_text_out,
    // status
    output logic         busy,
    output logic         grant_id
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e       state_q, state_d;
    logic         last_grant_q, last_grant_d;
    logic         grant_id_q, grant_id_d;
    logic [127:0] key_q, key_d;
    logic [127:0] text_q, text_d;
    logic [127:0] rsp0_data_q, rsp0_data_d;
    logic [127:0] rsp1_data_q, rsp1_data_d;
    logic         rsp0_err_q, rsp0_err_d;
    logic         rsp1_err_q, rsp1_err_d;
    logic         win0, win1;
    logic         rsp_hs;
    logic         timeout_hit;

    // On a tie the port that was not granted last wins; last_grant resets
    // to 1 so port 0 takes the first tie.
    assign win0 = req0_valid && (!req1_valid || last_grant_q);
    assign win1 = req1_valid && !win0;

`ifdef AES_SCHED_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == S_LOAD) begin
            wd_cnt_d = '0;
        end else if (state_q == S_WAIT && wd_cnt_q != WD_MAX) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
    end

    // The WAIT cycle whose increment carries the count to the limit is the
    // last one, so the job gets exactly TIMEOUT_CYCLES WAIT cycles.
    assign timeout_hit = (state_q == S_WAIT) && (wd_cnt_q == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign rsp0_err = rsp0_err_q;
    assign rsp1_err = rsp1_err_q;
`else
    logic unused_cfg;

    assign timeout_hit = 1'b0;
    assign rsp0_err    = 1'b0;
    assign rsp1_err    = 1'b0;
    assign unused_cfg  = (TIMEOUT_CYCLES != 0) | rsp0_err_q | rsp1_err_q;
`endif

    assign rsp_hs = grant_id_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        key_d        = key_q;
        text_d       = text_q;
        rsp0_data_d  = rsp0_data_q;
        rsp1_data_d  = rsp1_data_q;
        rsp0_err_d   = rsp0_err_q;
        rsp1_err_d   = rsp1_err_q;
        case (state_q)
            S_IDLE: begin
                if (win0 || win1) begin
                    grant_id_d   = win1;
                    last_grant_d = win1;
                    key_d        = win1 ? req1_key : req0_key;
                    text_d       = win1 ? req1_text : req0_text;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // done has priority over a watchdog expiry in the same cycle
                if (core_done) begin
                    if (grant_id_q) begin
                        rsp1_data_d = core_text_out;
                        rsp1_err_d  = 1'b0;
                    end else begin
                        rsp0_data_d = core_text_out;
                        rsp0_err_d  = 1'b0;
                    end
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    if (grant_id_q) begin
                        rsp1_data_d = '0;
                        rsp1_err_d  = 1'b1;
                    end else begin
                        rsp0_data_d = '0;
                        rsp0_err_d  = 1'b1;
                    end
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_hs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            key_q        <= '0;
            text_q       <= '0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
            rsp0_err_q   <= 1'b0;
            rsp1_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            key_q        <= key_d;
            text_q       <= text_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
            rsp0_err_q   <= rsp0_err_d;
            rsp1_err_q   <= rsp1_err_d;
        end
    end

    assign req0_ready   = (state_q == S_IDLE) && win0;
    assign req1_ready   = (state_q == S_IDLE) && win1;
    assign rsp0_valid   = (state_q == S_RESP) && !grant_id_q;
    assign rsp1_valid   = (state_q == S_RESP) && grant_id_q;
    assign rsp0_data    = rsp0_data_q;
    assign rsp1_data    = rsp1_data_q;
    assign core_ld      = (state_q == S_LOAD);
    assign core_key     = key_q;
    assign core_text_in = text_q;
    assign busy         = (state_q != S_IDLE);
    assign grant_id     = grant_id_q;

endmodule

// File: tb/tb_aes_core_sched.sv
// tb/tb_aes_core_sched.sv - scoreboard bench for aes_core_sched with a behavioural 12-cycle cipher core
module tb_aes_core_sched;

    localparam logic [127:0] FK  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FCT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [127:0] req0_key, req0_text, req1_key, req1_text;
    logic         rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
    logic [127:0] rsp0_data, rsp1_data;
    logic         core_ld, core_done, busy, grant_id;
    logic [127:0] core_key, core_text_in, core_text_out;

    typedef struct {
        logic         port;
        logic [127:0] data;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic expect_timeout = 1'b0;
    logic core_en = 1'b1;
    logic spur_done = 1'b0;
    int   cd = 0;
    logic [127:0] ct_q = '0;

    aes_core_sched #(.TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_key(req0_key), .req0_text(req0_text),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_key(req1_key), .req1_text(req1_text),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .core_ld(core_ld), .core_key(core_key), .core_text_in(core_text_in),
        .core_done(core_done), .core_text_out(core_text_out),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Stand-in cipher: the FIPS-197 vector maps to its known ciphertext,
    // anything else to an asymmetric mix of key and text.
    function automatic logic [127:0] model_ct(input logic [127:0] k, input logic [127:0] t);
        if (k == FK && t == FT) return FCT;
        return k ^ {t[63:0], t[127:64]} ^ 128'h5a5a_0f0f_3c3c_9696_a5a5_f0f0_c3c3_6969;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic exp_t make_exp(input logic p, input logic [127:0] k, input logic [127:0] t);
        exp_t e;
        e.port = p;
        e.data = expect_timeout ? 128'h0 : model_ct(k, t);
        e.err  = expect_timeout;
        return e;
    endfunction

    // core: done pulses 12 cycles after the ld cycle
    always @(posedge clk) begin
        if (rst) begin
            cd <= 0;
        end else if (core_ld) begin
            cd   <= 12;
            ct_q <= model_ct(core_key, core_text_in);
        end else if (cd > 0) begin
            cd <= cd - 1;
        end
    end
    assign core_done     = (core_en && cd == 1) | spur_done;
    assign core_text_out = ct_q;

    // scoreboard monitor: push on request handshake, pop on response handshake
    logic         m_v, m_r, m_e;
    logic [127:0] m_d;
    exp_t         m_x;
    always @(negedge clk) begin
        if (!rst) begin
            if (req0_valid && req0_ready) sb.push_back(make_exp(1'b0, req0_key, req0_text));
            if (req1_valid && req1_ready) sb.push_back(make_exp(1'b1, req1_key, req1_text));
            for (int p = 0; p < 2; p++) begin
                m_v = (p == 0) ? rsp0_valid : rsp1_valid;
                m_r = (p == 0) ? rsp0_ready : rsp1_ready;
                m_d = (p == 0) ? rsp0_data  : rsp1_data;
                m_e = (p == 0) ? rsp0_err   : rsp1_err;
                if (m_v && m_r) begin
                    vectors++;
                    if (sb.size() == 0) begin
                        miscompares++;
                        $display("FAIL sb_unexpected: port %0d data %h err %0b, no job outstanding", p, m_d, m_e);
                    end else begin
                        m_x = sb.pop_front();
                        if (m_x.port !== p[0] || m_x.data !== m_d || m_x.err !== m_e) begin
                            miscompares++;
                            $display("FAIL sb_rsp: got port %0d data %h err %0b, want port %0d data %h err %0b",
                                     p, m_d, m_e, m_x.port, m_x.data, m_x.err);
                        end
                    end
                end
            end
            vectors++;
            if (req0_ready && req1_ready) begin
                miscompares++;
                $display("FAIL both_ready: req0_ready %0b req1_ready %0b, want not both", req0_ready, req1_ready);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic submit(input int p, input logic [127:0] k, input logic [127:0] t);
        int  n;
        logic rdy;
        @(posedge clk); #1;
        if (p == 0) begin req0_key = k; req0_text = t; req0_valid = 1'b1; end
        else        begin req1_key = k; req1_text = t; req1_valid = 1'b1; end
        n = 0;
        do begin
            @(negedge clk); n++;
            rdy = (p == 0) ? req0_ready : req1_ready;
        end while (!rdy && n < 100);
        vectors++;
        if (!rdy) begin miscompares++; $display("FAIL submit_ready: port %0d ready 0 after %0d cycles, want 1", p, n); end
        @(posedge clk); #1;
        if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 300) begin @(negedge clk); n++; end
        vectors++;
        if (sb.size() != 0 || busy) begin
            miscompares++;
            $display("FAIL %s_drain: %0d responses pending busy %0b, want 0 and 0", name, sb.size(), busy);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, grant_id, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, core_ld} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: busy/gid/rdy0/rdy1/v0/v1/e0/e1/ld = %b, want 000000000",
                     {busy, grant_id, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, core_ld});
        end
        vectors++;
        if (core_key !== 128'h0 || core_text_in !== 128'h0) begin
            miscompares++; $display("FAIL reset_core: key %h text %h, want 0", core_key, core_text_in);
        end
        vectors++;
        if (rsp0_data !== 128'h0 || rsp1_data !== 128'h0) begin
            miscompares++; $display("FAIL reset_data: rsp0 %h rsp1 %h, want 0", rsp0_data, rsp1_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_fips();
        int t_ld, n_ld, t_rsp;
        t_ld = -1; n_ld = 0; t_rsp = -1;
        submit(0, FK, FT);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (core_ld) begin n_ld++; if (t_ld < 0) t_ld = k; end
            if (rsp0_valid && t_rsp < 0) t_rsp = k;
        end
        vectors++;
        if (t_ld !== 1 || n_ld !== 1) begin
            miscompares++; $display("FAIL fips_ld: first at T+%0d count %0d, want T+1 count 1", t_ld, n_ld);
        end
        vectors++;
        if (t_rsp !== 14) begin miscompares++; $display("FAIL fips_latency: rsp0_valid at T+%0d, want T+14", t_rsp); end
        vectors++;
        if (rsp0_data !== FCT || rsp0_err !== 1'b0) begin
            miscompares++; $display("FAIL fips_data: %h err %0b, want %h err 0", rsp0_data, rsp0_err, FCT);
        end
    endtask

    task automatic test_round_robin();
        logic [127:0] k0[3], t0[3], k1[3], t1[3];
        int   i0, i1;
        int   order[$];
        logic h0, h1;
        for (int j = 0; j < 3; j++) begin k0[j] = rnd128(); t0[j] = rnd128(); k1[j] = rnd128(); t1[j] = rnd128(); end
        do_reset();
        i0 = 0; i1 = 0;
        req0_key = k0[0]; req0_text = t0[0]; req0_valid = 1'b1;
        req1_key = k1[0]; req1_text = t1[0]; req1_valid = 1'b1;
        for (int c = 0; c < 400 && (i0 < 3 || i1 < 3); c++) begin
            @(negedge clk);
            h0 = req0_valid && req0_ready;
            h1 = req1_valid && req1_ready;
            vectors++;
            if (busy && (req0_ready || req1_ready)) begin
                miscompares++; $display("FAIL rr_ready_busy: rdy0 %0b rdy1 %0b while busy, want 0", req0_ready, req1_ready);
            end
            @(posedge clk); #1;
            if (h0) begin order.push_back(0); i0++; end
            if (h1) begin order.push_back(1); i1++; end
            req0_valid = (i0 < 3);
            req1_valid = (i1 < 3);
            if (i0 < 3) begin req0_key = k0[i0]; req0_text = t0[i0]; end
            if (i1 < 3) begin req1_key = k1[i1]; req1_text = t1[i1]; end
        end
        vectors++;
        if (order.size() != 6) begin
            miscompares++; $display("FAIL rr_count: %0d grants, want 6", order.size());
        end
        for (int j = 0; j < order.size(); j++) begin
            vectors++;
            if (order[j] != (j % 2)) begin
                miscompares++; $display("FAIL rr_order: grant %0d went to port %0d, want %0d", j, order[j], j % 2);
            end
        end
        wait_drain("rr");
    endtask

    task automatic test_backpressure();
        logic [127:0] d;
        int n;
        rsp1_ready = 1'b0;
        submit(1, rnd128(), rnd128());
        req0_key = rnd128(); req0_text = rnd128(); req0_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp1_valid && n < 50);
        d = rsp1_data;
        for (int k = 0; k < 20; k++) begin
            vectors++;
            if (rsp1_valid !== 1'b1 || rsp1_data !== d || busy !== 1'b1 || req0_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold: cyc %0d v1 %0b data %h busy %0b rdy0 %0b, want 1 %h 1 0",
                         k, rsp1_valid, rsp1_data, busy, req0_ready, d);
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp1_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || req0_ready !== 1'b1) begin
            miscompares++; $display("FAIL bp_release_idle: busy %0b rdy0 %0b, want 0 1", busy, req0_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (core_ld !== 1'b1 || grant_id !== 1'b0 || busy !== 1'b1) begin
            miscompares++; $display("FAIL bp_regrant: ld %0b gid %0b busy %0b, want 1 0 1", core_ld, grant_id, busy);
        end
        wait_drain("bp");
    endtask

    task automatic test_timeout();
        int t_rsp;
        t_rsp = -1;
        core_en = 1'b0;
`ifdef AES_SCHED_TIMEOUT_EN
        expect_timeout = 1'b1;
`endif
        submit(0, rnd128(), rnd128());
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (rsp0_valid && t_rsp < 0) t_rsp = k;
        end
`ifdef AES_SCHED_TIMEOUT_EN
        vectors++;
        if (t_rsp !== 22) begin miscompares++; $display("FAIL wd_latency: rsp0_valid at T+%0d, want T+22", t_rsp); end
        vectors++;
        if (rsp0_err !== 1'b1 || rsp0_data !== 128'h0) begin
            miscompares++; $display("FAIL wd_result: err %0b data %h, want 1 and 0", rsp0_err, rsp0_data);
        end
        wait_drain("wd");
`else
        vectors++;
        if (t_rsp !== -1 || busy !== 1'b1) begin
            miscompares++; $display("FAIL wd_absent: rsp at T+%0d busy %0b, want no response busy 1", t_rsp, busy);
        end
        do_reset();
`endif
        expect_timeout = 1'b0;
        core_en = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        logic saw;
        int   n;
        saw = 1'b0;
        submit(0, rnd128(), rnd128());
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        vectors++;
        if ({busy, grant_id, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, core_ld} !== 9'b0) begin
            miscompares++;
            $display("FAIL rstw_ctrl: busy/gid/rdy0/rdy1/v0/v1/e0/e1/ld = %b, want 000000000",
                     {busy, grant_id, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, core_ld});
        end
        vectors++;
        if (core_key !== 128'h0 || core_text_in !== 128'h0 || rsp0_data !== 128'h0 || rsp1_data !== 128'h0) begin
            miscompares++;
            $display("FAIL rstw_data: key %h text %h rsp0 %h rsp1 %h, want all 0", core_key, core_text_in, rsp0_data, rsp1_data);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid || busy) saw = 1'b1;
        end
        vectors++;
        if (saw !== 1'b0) begin miscompares++; $display("FAIL rstw_quiet: activity seen after reset, want none"); end
        @(posedge clk); #1;
        req0_key = rnd128(); req0_text = rnd128(); req0_valid = 1'b1;
        req1_key = rnd128(); req1_text = rnd128(); req1_valid = 1'b1;
        @(negedge clk);
        vectors++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            miscompares++; $display("FAIL rstw_tie: rdy0 %0b rdy1 %0b, want 1 0", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!req1_ready && n < 100);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_drain("rstw");
    endtask

    task automatic test_spurious();
        logic [127:0] d0, d1;
        int n;
        d0 = rsp0_data; d1 = rsp1_data;
        @(posedge clk); #1; spur_done = 1'b1;
        @(posedge clk); #1; spur_done = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || rsp0_data !== d0 || rsp1_data !== d1) begin
            miscompares++;
            $display("FAIL spur_idle: busy %0b v0 %0b v1 %0b d0 %h d1 %h, want 0 0 0 %h %h",
                     busy, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, d0, d1);
        end
        rsp0_ready = 1'b0;
        submit(0, rnd128(), rnd128());
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp0_valid && n < 50);
        d0 = rsp0_data;
        @(posedge clk); #1; spur_done = 1'b1;
        @(posedge clk); #1; spur_done = 1'b0;
        @(negedge clk);
        vectors++;
        if (rsp0_valid !== 1'b1 || busy !== 1'b1 || rsp0_data !== d0) begin
            miscompares++;
            $display("FAIL spur_resp: v0 %0b busy %0b d0 %h, want 1 1 %h", rsp0_valid, busy, rsp0_data, d0);
        end
        @(posedge clk); #1;
        rsp0_ready = 1'b1;
        wait_drain("spur");
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_key = '0; req0_text = '0; req1_key = '0; req1_text = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        test_reset();
        test_fips();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_reset_mid_wait();
        test_spurious();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: bench did not finish, want finish");
        $fatal(1);
    end

endmodule
